// File: rtl/eth_fdb_pkg.sv
// Shared definitions for the Ethernet forwarding database: FSM encodings,
// default parameter values and MAC address helpers.
package eth_fdb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2,
        ST_SWEEP  = 2'd3
    } fdb_state_t;

    // Defaults shared by the switch top and the header capture logic.
    localparam int DEF_NPORTS  = 4;
    localparam int DEF_MAC_W   = 24;
    localparam int DEF_ENTRIES = 16;
    localparam int DEF_AGE_W   = 3;

    // The group (multicast) flag sits 8 bits below the top of the compared MAC field.
    localparam int MCAST_OFS = 8;

    function automatic int mcast_bit(input int mac_w);
        return mac_w - MCAST_OFS;
    endfunction

endpackage

// File: rtl/eth_fdb_if.sv
// Request/response bundle between the per-port header capture (master)
// and the forwarding database (slave).
interface eth_fdb_if
    import eth_fdb_pkg::*;
#(
    parameter int NPORTS = DEF_NPORTS,
    parameter int MAC_W  = DEF_MAC_W
) ();
    logic [NPORTS-1:0]       req_valid;
    logic [NPORTS*MAC_W-1:0] req_dst;
    logic [NPORTS*MAC_W-1:0] req_src;
    logic [NPORTS-1:0]       req_ready;
    logic [NPORTS-1:0]       resp_valid;
    logic [NPORTS-1:0]       resp_mask;

    modport master (
        output req_valid, req_dst, req_src,
        input  req_ready, resp_valid, resp_mask
    );

    modport slave (
        input  req_valid, req_dst, req_src,
        output req_ready, resp_valid, resp_mask
    );
endinterface

// File: rtl/eth_fdb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found when
// scanning upwards from the pointer, wrapping at N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    input  logic          enable,
    output logic [N-1:0]  grant
);
    // Priority scan starting at the pointer position.
    always_comb begin
        int   k;
        logic found;
        grant = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(pointer) + i) % N;
            if (enable && !found && req[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/eth_fdb.sv
// Forwarding database: arbitrates per-port header lookups, returns the
// egress mask, learns source MAC bindings, ages and flushes entries.
module eth_fdb
    import eth_fdb_pkg::*;
#(
    parameter int NPORTS  = DEF_NPORTS,
    parameter int MAC_W   = DEF_MAC_W,
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int AGE_W   = DEF_AGE_W
) (
    input  logic                     sysclk,
    input  logic                     reset,
    eth_fdb_if.slave                 bus,
    input  logic                     age_tick,
    input  logic                     flush,
    output logic                     busy,
    output logic [$clog2(ENTRIES):0] fdb_count
);
    localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int EW     = $clog2(ENTRIES);
    localparam int CW     = EW + 1;
    localparam int MC_BIT = mcast_bit(MAC_W);

    localparam logic [MAC_W-1:0]  MAC_BCAST = '1;
    localparam logic [NPORTS-1:0] ALL_PORTS = '1;
    localparam logic [NPORTS-1:0] ONE_PORT  = NPORTS'(1);
    localparam logic [AGE_W-1:0]  AGE_MAX   = '1;

    // Control state
    fdb_state_t        r_state;
    logic [ENTRIES-1:0] r_valid;
    logic              r_pending;
    logic [PW-1:0]     r_ptr;
    logic [EW-1:0]     r_repl;
    logic [EW-1:0]     r_idx;
    logic [NPORTS-1:0] r_req_ready;
    logic [NPORTS-1:0] r_resp_valid;
    logic [NPORTS-1:0] r_resp_mask;
    logic              r_busy;
    logic [CW-1:0]     r_count;

    // Table contents and captured request (no reset needed: gated by r_valid / FSM)
    logic [MAC_W-1:0]  r_mac  [ENTRIES];
    logic [PW-1:0]     r_port [ENTRIES];
    logic [AGE_W-1:0]  r_age  [ENTRIES];
    logic [MAC_W-1:0]  r_dst;
    logic [MAC_W-1:0]  r_src;
    logic [PW-1:0]     r_g;
    logic [NPORTS-1:0] r_mask;

    logic [NPORTS-1:0] w_grant;
    logic [PW-1:0]     w_gidx;
    logic              w_arb_en;
    logic              w_start;
    logic [MAC_W-1:0]  w_sel_dst;
    logic [MAC_W-1:0]  w_sel_src;
    logic              w_dst_hit;
    logic [PW-1:0]     w_dst_q;
    logic              w_src_hit;
    logic [EW-1:0]     w_src_idx;
    logic              w_free;
    logic [EW-1:0]     w_free_idx;
    logic [NPORTS-1:0] w_g_onehot;
    logic [NPORTS-1:0] w_flood;
    logic [NPORTS-1:0] w_mask;
    logic              w_learn_en;
    logic [EW-1:0]     w_learn_idx;
    logic              w_repl_adv;
    logic              w_age_dec;

    function automatic logic [CW-1:0] popcount(input logic [ENTRIES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < ENTRIES; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    // Arbitration only happens in an idle cycle with no flush or pending sweep.
    assign w_arb_en = (r_state == ST_IDLE) && !flush && !r_pending;
    assign w_start  = |w_grant;

    rr_arbiter #(.N(NPORTS), .PW(PW)) u_arb (
        .req     (bus.req_valid),
        .pointer (r_ptr),
        .enable  (w_arb_en),
        .grant   (w_grant)
    );

    // Encode the one-hot grant and select that port's header fields.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_grant[i]) w_gidx = PW'(i);
        end
        w_sel_dst = bus.req_dst[w_gidx*MAC_W +: MAC_W];
        w_sel_src = bus.req_src[w_gidx*MAC_W +: MAC_W];
    end

    // Parallel CAM match of captured dst/src plus lowest free slot; the
    // descending scan lets the lowest index win.
    always_comb begin
        w_dst_hit  = 1'b0;
        w_dst_q    = '0;
        w_src_hit  = 1'b0;
        w_src_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (r_valid[e] && r_mac[e] == r_dst) begin
                w_dst_hit = 1'b1;
                w_dst_q   = r_port[e];
            end
            if (r_valid[e] && r_mac[e] == r_src) begin
                w_src_hit = 1'b1;
                w_src_idx = EW'(e);
            end
            if (!r_valid[e]) begin
                w_free     = 1'b1;
                w_free_idx = EW'(e);
            end
        end
    end

    // Egress decision on pre-learn contents, plus learn/age write controls.
    always_comb begin
        w_g_onehot = ONE_PORT << r_g;
        w_flood    = ALL_PORTS & ~w_g_onehot;
        if (r_dst == MAC_BCAST || r_dst[MC_BIT])
            w_mask = w_flood;
        else if (w_dst_hit)
            w_mask = (w_dst_q == r_g) ? '0 : (ONE_PORT << w_dst_q);
        else
            w_mask = w_flood;

        w_learn_en  = (r_state == ST_LOOKUP) && !r_src[MC_BIT];
        w_learn_idx = w_src_hit ? w_src_idx : (w_free ? w_free_idx : r_repl);
        w_repl_adv  = w_learn_en && !w_src_hit && !w_free;
        w_age_dec   = (r_state == ST_SWEEP) && !flush && r_valid[r_idx] && (r_age[r_idx] != '0);
    end

    // Control FSM: sequencing, valid bits, pointers and registered outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_valid      <= '0;
            r_pending    <= 1'b0;
            r_ptr        <= '0;
            r_repl       <= '0;
            r_idx        <= '0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_mask  <= '0;
            r_busy       <= 1'b0;
            r_count      <= '0;
        end else begin
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_mask  <= '0;
            r_count      <= popcount(r_valid);
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        r_valid   <= '0;
                        r_pending <= 1'b0;
                    end else if (r_pending) begin
                        r_state   <= ST_SWEEP;
                        r_idx     <= '0;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                    end else if (w_start) begin
                        r_req_ready <= w_grant;
                        r_ptr       <= (w_gidx == PW'(NPORTS - 1)) ? '0 : w_gidx + 1'b1;
                        r_state     <= ST_LOOKUP;
                        r_busy      <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    if (w_learn_en) r_valid[w_learn_idx] <= 1'b1;
                    if (w_repl_adv) r_repl <= (r_repl == EW'(ENTRIES - 1)) ? '0 : r_repl + 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_resp_valid <= w_g_onehot;
                    r_resp_mask  <= r_mask;
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                end
                ST_SWEEP: begin
                    if (flush) begin
                        r_valid <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_valid[r_idx] && r_age[r_idx] == '0) r_valid[r_idx] <= 1'b0;
                        if (r_idx == EW'(ENTRIES - 1)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // A tick is never lost: it re-arms pending even on the cycle it is cleared.
            if (age_tick) r_pending <= 1'b1;
        end
    end

    // Datapath: request capture, mask hold, table MAC/port/age writes.
    always_ff @(posedge sysclk) begin
        if (w_start) begin
            r_dst <= w_sel_dst;
            r_src <= w_sel_src;
            r_g   <= w_gidx;
        end
        if (r_state == ST_LOOKUP) r_mask <= w_mask;
        if (w_learn_en) begin
            if (!w_src_hit) r_mac[w_learn_idx] <= r_src;
            r_port[w_learn_idx] <= r_g;
            r_age[w_learn_idx]  <= AGE_MAX;
        end
        if (w_age_dec) r_age[r_idx] <= r_age[r_idx] - 1'b1;
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_mask  = r_resp_mask;
    assign busy           = r_busy;
    assign fdb_count      = r_count;

endmodule

// File: tb/tb_eth_fdb.sv
// Directed bench for eth_fdb with a 4-port, 4-entry, 2-bit-age table.
module tb_eth_fdb;
    localparam int NP = 4;
    localparam int MW = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       age_tick = 1'b0;
    logic       flush = 1'b0;
    logic       busy;
    logic [2:0] fdb_count;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    eth_fdb_if #(.NPORTS(NP), .MAC_W(MW)) ifc ();

    eth_fdb #(.NPORTS(NP), .MAC_W(MW), .ENTRIES(4), .AGE_W(2)) dut (
        .sysclk    (clk),
        .reset     (rst),
        .bus       (ifc),
        .age_tick  (age_tick),
        .flush     (flush),
        .busy      (busy),
        .fdb_count (fdb_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One lookup from port p; checks grant, response port, mask and latency.
    task automatic send(input int p, input logic [23:0] src, input logic [23:0] dst,
                        input logic [3:0] exp_mask, input string tag);
        int         t_rdy;
        bit         got;
        logic [3:0] oh;
        oh    = 4'b0001 << p;
        t_rdy = 0;
        @(negedge clk);
        ifc.req_src[p*MW +: MW] = src;
        ifc.req_dst[p*MW +: MW] = dst;
        ifc.req_valid[p] = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ifc.req_ready != '0) begin
                got   = 1;
                t_rdy = cyc;
                chk({tag, " grant"}, 32'(ifc.req_ready), 32'(oh));
            end
        end
        ifc.req_valid[p] = 1'b0;
        if (!got) begin
            chk({tag, " grant timeout"}, 0, 1);
            return;
        end
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (ifc.resp_valid != '0) begin
                got = 1;
                chk({tag, " resp port"}, 32'(ifc.resp_valid), 32'(oh));
                chk({tag, " mask"}, 32'(ifc.resp_mask), 32'(exp_mask));
                chk({tag, " latency"}, cyc - t_rdy, 2);
            end
        end
        if (!got) chk({tag, " resp timeout"}, 0, 1);
    endtask

    // All four ports request continuously for 12 grants.
    task automatic fair_test();
        logic [3:0] eg;
        int         tr;
        bit         got;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            ifc.req_src[p*MW +: MW] = 24'h010000 | 24'(p);
            ifc.req_dst[p*MW +: MW] = 24'hFFFFFF;
        end
        ifc.req_valid = 4'hF;
        for (int i = 0; i < 12; i++) begin
            eg  = 4'b0001 << (i % 4);
            got = 0;
            tr  = 0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                if (ifc.req_ready != '0) begin
                    got = 1;
                    tr  = cyc;
                    chk("rr grant", 32'(ifc.req_ready), 32'(eg));
                end
            end
            if (!got) begin
                chk("rr grant timeout", 0, 1);
                break;
            end
            got = 0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                if (ifc.resp_valid != '0) begin
                    got = 1;
                    if (i == 11) ifc.req_valid = '0;
                    chk("rr resp port", 32'(ifc.resp_valid), 32'(eg));
                    chk("rr mask", 32'(ifc.resp_mask), 32'(4'hF & ~eg));
                    chk("rr latency", cyc - tr, 2);
                    chk("rr ready/resp overlap", 32'(ifc.req_ready), 0);
                end
            end
            if (!got) begin
                chk("rr resp timeout", 0, 1);
                break;
            end
        end
        ifc.req_valid = '0;
    endtask

    // Pulse age_tick and wait for the resulting sweep to finish.
    task automatic tick_sweep(input string tag);
        bit got;
        @(negedge clk);
        age_tick = 1'b1;
        @(negedge clk);
        age_tick = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (busy) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            chk({tag, " sweep start timeout"}, 0, 1);
            return;
        end
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (!busy) got = 1;
        end
        if (!got) chk({tag, " sweep end timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit seen;
        ifc.req_valid = '0;
        ifc.req_src   = '0;
        ifc.req_dst   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst req_ready", 32'(ifc.req_ready), 0);
        chk("rst resp_valid", 32'(ifc.resp_valid), 0);
        chk("rst resp_mask", 32'(ifc.resp_mask), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst count", 32'(fdb_count), 0);
        rst = 1'b0;

        // Round-robin fairness with multicast sources (nothing learned)
        fair_test();
        @(negedge clk);
        chk("rr count", 32'(fdb_count), 0);

        // Learn then unicast
        send(1, 24'h0A0001, 24'h0C0002, 4'b1101, "learn1");
        send(2, 24'h0C0002, 24'h0A0001, 4'b0010, "unicast");
        @(negedge clk);
        chk("learn count", 32'(fdb_count), 2);
        send(0, 24'h010000, 24'h0C0002, 4'b0100, "unicast p2");

        // Filter, broadcast, multicast
        send(1, 24'h0A0001, 24'h0A0001, 4'b0000, "filter");
        send(3, 24'h010203, 24'hFFFFFF, 4'b0111, "bcast");
        send(2, 24'h030000, 24'h01AAAA, 4'b1011, "mcast dst");
        @(negedge clk);
        chk("mcast src not learned", 32'(fdb_count), 2);

        // Flush from IDLE
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        @(negedge clk);
        chk("flush idle count", 32'(fdb_count), 0);
        send(2, 24'h010000, 24'h0A0001, 4'b1011, "post-flush miss");

        // Aging with a refresh in between
        send(0, 24'h0E0004, 24'h0C0002, 4'b1110, "age learn");
        tick_sweep("age1");
        tick_sweep("age2");
        tick_sweep("age3");
        chk("age 3 ticks count", 32'(fdb_count), 1);
        send(1, 24'h0E0004, 24'h0E0004, 4'b0001, "age refresh");
        tick_sweep("age4");
        tick_sweep("age5");
        tick_sweep("age6");
        chk("age refreshed count", 32'(fdb_count), 1);
        tick_sweep("age7");
        chk("age expired count", 32'(fdb_count), 0);

        // Table full: fifth source replaces entry 0
        send(0, 24'h200001, 24'hFFFFFF, 4'b1110, "full1");
        send(0, 24'h200002, 24'hFFFFFF, 4'b1110, "full2");
        send(0, 24'h200003, 24'hFFFFFF, 4'b1110, "full3");
        send(0, 24'h200004, 24'hFFFFFF, 4'b1110, "full4");
        @(negedge clk);
        chk("full count 4", 32'(fdb_count), 4);
        send(0, 24'h200005, 24'hFFFFFF, 4'b1110, "full5");
        @(negedge clk);
        chk("full count stays 4", 32'(fdb_count), 4);
        send(2, 24'h010000, 24'h200001, 4'b1011, "evicted miss");
        send(2, 24'h010000, 24'h200002, 4'b0001, "kept hit");
        send(1, 24'h010000, 24'h200005, 4'b0001, "new hit");

        // Flush during a sweep
        @(negedge clk); age_tick = 1'b1;
        @(negedge clk); age_tick = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (busy) got = 1;
            else @(negedge clk);
        end
        chk("flush sweep started", 32'(got), 1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush sweep busy", 32'(busy), 0);
        @(negedge clk);
        chk("flush sweep count", 32'(fdb_count), 0);

        // Reset while a lookup is in flight
        send(3, 24'h0A0001, 24'hFFFFFF, 4'b0111, "pre-rst");
        @(negedge clk);
        chk("pre-rst count", 32'(fdb_count), 1);
        ifc.req_src[2*MW +: MW] = 24'h010000;
        ifc.req_dst[2*MW +: MW] = 24'hFFFFFF;
        ifc.req_valid[2] = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (ifc.req_ready != '0) got = 1;
        end
        chk("rst-lookup grant seen", 32'(got), 1);
        rst = 1'b1;
        ifc.req_valid = '0;
        @(negedge clk);
        chk("mid-rst req_ready", 32'(ifc.req_ready), 0);
        chk("mid-rst resp_valid", 32'(ifc.resp_valid), 0);
        chk("mid-rst resp_mask", 32'(ifc.resp_mask), 0);
        chk("mid-rst busy", 32'(busy), 0);
        chk("mid-rst count", 32'(fdb_count), 0);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.resp_valid != '0) seen = 1;
        end
        chk("no resp after rst", 32'(seen), 0);
        chk("idle after rst", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
